// File: rtl/draw_call_scheduler.sv
// Draw-call scheduler: buffers draw calls, then per frame configures the model
// buffer and launches the transform pipeline once for every non-empty draw.
module draw_call_scheduler #(
    parameter int unsigned MAX_DRAWS      = 16,
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned COUNT_WIDTH    = 14,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_dc_valid,
    output logic                   o_dc_ready,
    input  logic [ADDR_WIDTH-1:0]  i_dc_vertex_base,
    input  logic [COUNT_WIDTH-1:0] i_dc_vertex_count,
    input  logic [ADDR_WIDTH-1:0]  i_dc_index_base,
    input  logic [COUNT_WIDTH-1:0] i_dc_tri_count,
    input  logic                   i_frame_start,
    output logic                   o_frame_done,
    output logic                   o_busy,
    output logic                   o_error,
    input  logic                   i_error_clear,
    output logic                   o_mb_load,
    output logic [ADDR_WIDTH-1:0]  o_mb_vertex_base,
    output logic [COUNT_WIDTH-1:0] o_mb_vertex_count,
    output logic [ADDR_WIDTH-1:0]  o_mb_index_base,
    output logic [COUNT_WIDTH-1:0] o_mb_tri_count,
    output logic                   o_tp_start,
    input  logic                   i_tp_ready,
    input  logic                   i_tp_done,
    output logic [COUNT_WIDTH-1:0] o_draws_issued,
    output logic [COUNT_WIDTH-1:0] o_draws_skipped
);

    localparam int unsigned PTR_W   = (MAX_DRAWS > 1) ? $clog2(MAX_DRAWS) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 * ADDR_WIDTH + 2 * COUNT_WIDTH;
    localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TC_LSB  = 0;
    localparam int unsigned IB_LSB  = COUNT_WIDTH;
    localparam int unsigned VC_LSB  = COUNT_WIDTH + ADDR_WIDTH;
    localparam int unsigned VB_LSB  = 2 * COUNT_WIDTH + ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_FRAME_DONE
    } state_t;

    state_t state, state_d;

    logic [ENTRY_W-1:0]     fifo_mem [MAX_DRAWS];
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [CNT_W-1:0]       fill, fill_d;
    logic [TMR_W-1:0]       wait_cnt;

    logic [ENTRY_W-1:0]     head;
    logic [ADDR_WIDTH-1:0]  head_vbase, head_ibase;
    logic [COUNT_WIDTH-1:0] head_vcount, head_tcount;
    logic                   head_ok, push, skip, draw_done, timeout, pop, more;

    logic dc_ready_d, busy_d, frame_done_d, mb_load_d, tp_start_d;

    assign head        = fifo_mem[rd_ptr];
    assign head_vbase  = head[VB_LSB +: ADDR_WIDTH];
    assign head_vcount = head[VC_LSB +: COUNT_WIDTH];
    assign head_ibase  = head[IB_LSB +: ADDR_WIDTH];
    assign head_tcount = head[TC_LSB +: COUNT_WIDTH];
    assign head_ok     = (head_vcount != '0) && (head_tcount != '0);

    assign push      = i_dc_valid && o_dc_ready;
    assign skip      = (state == S_LOAD) && !head_ok;
    assign draw_done = (state == S_WAIT) && i_tp_done;
    assign timeout   = (state == S_WAIT) && !i_tp_done
                       && (wait_cnt == TMR_W'(TIMEOUT_CYCLES - 1));
    assign pop       = skip || draw_done;
    // Entries remain once the current head has been retired
    assign more      = fill > CNT_W'(1);

    always_comb begin
        fill_d = fill + CNT_W'(push) - CNT_W'(pop);
        if (timeout) begin
            fill_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (i_frame_start) begin
                    state_d = ((fill != '0) || push) ? S_LOAD : S_FRAME_DONE;
                end
            end
            S_LOAD: begin
                if (head_ok) begin
                    state_d = S_START;
                end else begin
                    state_d = more ? S_LOAD : S_FRAME_DONE;
                end
            end
            S_START: begin
                if (i_tp_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_tp_done) begin
                    state_d = more ? S_LOAD : S_FRAME_DONE;
                end else if (timeout) begin
                    state_d = S_FRAME_DONE;
                end
            end
            S_FRAME_DONE: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Next values of the registered control outputs
    always_comb begin
        dc_ready_d   = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        mb_load_d    = 1'b0;
        tp_start_d   = 1'b0;
        dc_ready_d   = (state_d == S_IDLE) && (fill_d != CNT_W'(MAX_DRAWS));
        busy_d       = (state != S_IDLE) || (state_d != S_IDLE);
        frame_done_d = (state == S_FRAME_DONE);
        mb_load_d    = (state == S_LOAD) && head_ok;
        tp_start_d   = (state == S_START) && i_tp_ready;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {i_dc_vertex_base, i_dc_vertex_count,
                                 i_dc_index_base, i_dc_tri_count};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            fill              <= '0;
            wait_cnt          <= '0;
            o_dc_ready        <= 1'b0;
            o_busy            <= 1'b0;
            o_frame_done      <= 1'b0;
            o_mb_load         <= 1'b0;
            o_tp_start        <= 1'b0;
            o_error           <= 1'b0;
            o_mb_vertex_base  <= '0;
            o_mb_vertex_count <= '0;
            o_mb_index_base   <= '0;
            o_mb_tri_count    <= '0;
            o_draws_issued    <= '0;
            o_draws_skipped   <= '0;
        end else begin
            fill         <= fill_d;
            o_dc_ready   <= dc_ready_d;
            o_busy       <= busy_d;
            o_frame_done <= frame_done_d;
            o_mb_load    <= mb_load_d;
            o_tp_start   <= tp_start_d;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // A timeout discards everything still queued
            if (timeout) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            wait_cnt <= (state == S_WAIT) ? wait_cnt + TMR_W'(1) : '0;

            if (timeout) begin
                o_error <= 1'b1;
            end else if (i_error_clear) begin
                o_error <= 1'b0;
            end

            if (mb_load_d) begin
                o_mb_vertex_base  <= head_vbase;
                o_mb_vertex_count <= head_vcount;
                o_mb_index_base   <= head_ibase;
                o_mb_tri_count    <= head_tcount;
            end

            if ((state == S_IDLE) && i_frame_start) begin
                o_draws_issued  <= '0;
                o_draws_skipped <= '0;
            end else begin
                if (draw_done && !(&o_draws_issued)) begin
                    o_draws_issued <= o_draws_issued + COUNT_WIDTH'(1);
                end
                if (skip && !(&o_draws_skipped)) begin
                    o_draws_skipped <= o_draws_skipped + COUNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_draw_call_scheduler.sv
// Bench for draw_call_scheduler: frame vector table, multi-cycle corner
// sequences and random frames checked against a queue-based model.
module tb_draw_call_scheduler;

    localparam int unsigned AW   = 14;
    localparam int unsigned CW   = 14;
    localparam int unsigned MAXD = 16;
    localparam int unsigned TMO  = 100;

    typedef struct packed {
        logic [AW-1:0] vb;
        logic [CW-1:0] vc;
        logic [AW-1:0] ib;
        logic [CW-1:0] tc;
    } entry_t;

    typedef struct {
        int n;
        int zmask;
        bit fs_last;
        int exp_iss;
        int exp_skp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_dc_valid;
    logic          o_dc_ready;
    logic [AW-1:0] i_dc_vertex_base;
    logic [CW-1:0] i_dc_vertex_count;
    logic [AW-1:0] i_dc_index_base;
    logic [CW-1:0] i_dc_tri_count;
    logic          i_frame_start;
    logic          o_frame_done;
    logic          o_busy;
    logic          o_error;
    logic          i_error_clear;
    logic          o_mb_load;
    logic [AW-1:0] o_mb_vertex_base;
    logic [CW-1:0] o_mb_vertex_count;
    logic [AW-1:0] o_mb_index_base;
    logic [CW-1:0] o_mb_tri_count;
    logic          o_tp_start;
    logic          i_tp_ready;
    logic          i_tp_done;
    logic [CW-1:0] o_draws_issued;
    logic [CW-1:0] o_draws_skipped;

    draw_call_scheduler #(
        .MAX_DRAWS(MAXD), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_dc_valid(i_dc_valid), .o_dc_ready(o_dc_ready),
        .i_dc_vertex_base(i_dc_vertex_base), .i_dc_vertex_count(i_dc_vertex_count),
        .i_dc_index_base(i_dc_index_base), .i_dc_tri_count(i_dc_tri_count),
        .i_frame_start(i_frame_start), .o_frame_done(o_frame_done),
        .o_busy(o_busy), .o_error(o_error), .i_error_clear(i_error_clear),
        .o_mb_load(o_mb_load), .o_mb_vertex_base(o_mb_vertex_base),
        .o_mb_vertex_count(o_mb_vertex_count), .o_mb_index_base(o_mb_index_base),
        .o_mb_tri_count(o_mb_tri_count),
        .o_tp_start(o_tp_start), .i_tp_ready(i_tp_ready), .i_tp_done(i_tp_done),
        .o_draws_issued(o_draws_issued), .o_draws_skipped(o_draws_skipped)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     n_load = 0;
    int     n_start = 0;
    int     n_done = 0;
    int     done_cyc = 0;
    int     load_cycs[$];
    int     start_cycs[$];
    entry_t exp_q[$];
    int     model_fill = 0;
    bit     tp_auto = 1'b1;
    int     tp_delay = 10;
    bit     ready_rand = 1'b0;
    bit     ready_force = 1'b1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Observes pulses and checks every model-buffer load against the expected draw order
    initial forever begin
        @(negedge clk);
        cyc++;
        if (o_mb_load === 1'b1) begin
            load_cycs.push_back(cyc);
            if (n_load < exp_q.size())
                check("mb_fields", {o_mb_vertex_base, o_mb_vertex_count,
                                    o_mb_index_base, o_mb_tri_count}, exp_q[n_load]);
            else
                check("mb_unexpected_load", 64'(n_load + 1), 64'(exp_q.size()));
            n_load++;
        end
        if (o_tp_start === 1'b1) begin
            start_cycs.push_back(cyc);
            n_start++;
        end
        if (o_frame_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Transform pipeline stand-in: answers each start with a done after tp_delay cycles
    initial begin
        i_tp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tp_start === 1'b1 && tp_auto) begin
                repeat (tp_delay - 1) @(negedge clk);
                #1 i_tp_done = 1'b1;
                @(negedge clk);
                #1 i_tp_done = 1'b0;
            end
        end
    end

    initial begin
        i_tp_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            i_tp_ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_force;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic entry_t rand_entry();
        entry_t e;
        e.vb = AW'($urandom);
        e.vc = CW'($urandom_range(1, (1 << CW) - 1));
        e.ib = AW'($urandom);
        e.tc = CW'($urandom_range(1, (1 << CW) - 1));
        return e;
    endfunction

    // Drives one enqueue attempt and updates the model; caller advances the clock
    task automatic enq(input entry_t e, input string nm);
        bit acc;
        i_dc_valid        = 1'b1;
        i_dc_vertex_base  = e.vb;
        i_dc_vertex_count = e.vc;
        i_dc_index_base   = e.ib;
        i_dc_tri_count    = e.tc;
        acc = (model_fill < MAXD);
        check({nm, "_dc_ready"}, 64'(o_dc_ready), 64'(acc));
        if (acc) begin
            model_fill++;
            if (e.vc != '0 && e.tc != '0) exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int base, input string nm);
        int k = 0;
        while (n_done == base && k < 3000) begin
            tick();
            k++;
        end
        check({nm, "_frame_done"}, 64'(n_done - base), 64'd1);
    endtask

    task automatic run_frame(input int n, input int zmask, input bit fs_last,
                             input int ex_iss, input int ex_skp, input string nm);
        int bl = n_load;
        int bs = n_start;
        int bd = n_done;
        int c0 = -100;
        entry_t e;
        for (int i = 0; i < n; i++) begin
            e = rand_entry();
            if (((zmask >> i) & 1) != 0) begin
                if ((i % 2) == 1) e.tc = '0;
                else              e.vc = '0;
            end
            enq(e, nm);
            if (fs_last && i == n - 1) begin
                i_frame_start = 1'b1;
                c0 = cyc;
            end
            tick();
        end
        i_dc_valid = 1'b0;
        if (!(fs_last && n > 0)) begin
            i_frame_start = 1'b1;
            c0 = cyc;
            tick();
        end
        i_frame_start = 1'b0;
        check({nm, "_busy"}, 64'(o_busy), 64'd1);
        wait_done(bd, nm);
        if (n == 0)
            check({nm, "_empty_latency"}, 64'(done_cyc - c0), 64'd2);
        else if (ex_iss > 0 && (zmask & 1) == 0 && load_cycs.size() > bl)
            check({nm, "_load_latency"}, 64'(load_cycs[bl] - c0), 64'd2);
        check({nm, "_loads"}, 64'(n_load - bl), 64'(ex_iss));
        check({nm, "_starts"}, 64'(n_start - bs), 64'(ex_iss));
        check({nm, "_issued"}, 64'(o_draws_issued), 64'(ex_iss));
        check({nm, "_skipped"}, 64'(o_draws_skipped), 64'(ex_skp));
        model_fill = 0;
        tick();
        check({nm, "_idle_busy"}, 64'(o_busy), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int bl, bs, bd, s, k, acc_n, skp;

        vecs[0] = '{3, 'b010, 1'b0, 2, 1};
        vecs[1] = '{0, 0, 1'b0, 0, 0};
        vecs[2] = '{1, 1, 1'b0, 0, 1};
        vecs[3] = '{4, 0, 1'b1, 4, 0};
        vecs[4] = '{5, 'b10101, 1'b1, 2, 3};
        vecs[5] = '{17, 0, 1'b0, 16, 0};
        vecs[6] = '{2, 'b11, 1'b0, 0, 2};

        rstn = 1'b0;
        i_dc_valid = 1'b0;
        i_dc_vertex_base = '0;
        i_dc_vertex_count = '0;
        i_dc_index_base = '0;
        i_dc_tri_count = '0;
        i_frame_start = 1'b0;
        i_error_clear = 1'b0;
        repeat (3) tick();
        check("in_reset_dc_ready", 64'(o_dc_ready), 64'd0);
        rstn = 1'b1;
        tick();
        check("post_reset_dc_ready", 64'(o_dc_ready), 64'd1);
        check("post_reset_busy", 64'(o_busy), 64'd0);
        check("post_reset_error", 64'(o_error), 64'd0);
        check("post_reset_counts", 64'({o_draws_issued, o_draws_skipped}), 64'd0);

        tp_delay = 10;
        for (int v = 0; v < 7; v++)
            run_frame(vecs[v].n, vecs[v].zmask, vecs[v].fs_last,
                      vecs[v].exp_iss, vecs[v].exp_skp, $sformatf("vec%0d", v));

        // Pipeline not ready: the start must wait and then fire only once
        ready_rand = 1'b0;
        ready_force = 1'b0;
        tp_delay = 3;
        bl = n_load; bs = n_start; bd = n_done;
        enq(rand_entry(), "hold");
        tick();
        i_dc_valid = 1'b0;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        k = 0;
        while (n_load == bl && k < 20) begin tick(); k++; end
        check("hold_loaded", 64'(n_load - bl), 64'd1);
        repeat (50) tick();
        check("hold_no_start", 64'(n_start - bs), 64'd0);
        ready_force = 1'b1;
        wait_done(bd, "hold");
        check("hold_one_start", 64'(n_start - bs), 64'd1);
        check("hold_issued", 64'(o_draws_issued), 64'd1);
        model_fill = 0;
        tick();

        // Pipeline never completes: timeout, flush, sticky error
        tp_auto = 1'b0;
        bl = n_load; bs = n_start; bd = n_done;
        for (int i = 0; i < 3; i++) begin
            enq(rand_entry(), "tmo");
            tick();
        end
        i_dc_valid = 1'b0;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        k = 0;
        while (n_start == bs && k < 50) begin tick(); k++; end
        s = (start_cycs.size() > bs) ? start_cycs[bs] : cyc;
        k = 0;
        while (o_error !== 1'b1 && k < 300) begin tick(); k++; end
        check("timeout_cycle", 64'(cyc - s), 64'(TMO));
        wait_done(bd, "tmo");
        check("tmo_loads", 64'(n_load - bl), 64'd1);
        check("tmo_issued", 64'(o_draws_issued), 64'd0);
        while (exp_q.size() > n_load) void'(exp_q.pop_back());
        model_fill = 0;
        tick();
        check("tmo_error_sticky", 64'(o_error), 64'd1);
        run_frame(0, 0, 1'b0, 0, 0, "post_tmo");
        check("tmo_error_kept", 64'(o_error), 64'd1);
        i_error_clear = 1'b1;
        tick();
        i_error_clear = 1'b0;
        check("error_cleared", 64'(o_error), 64'd0);
        tp_auto = 1'b1;

        // Reset while the second of four draws is running
        tp_delay = 30;
        bl = n_load; bs = n_start; bd = n_done;
        for (int i = 0; i < 4; i++) begin
            enq(rand_entry(), "rst");
            tick();
        end
        i_dc_valid = 1'b0;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        k = 0;
        while (n_start < bs + 2 && k < 200) begin tick(); k++; end
        repeat (5) tick();
        rstn = 1'b0;
        tick();
        check("rst_ctrl_outputs", 64'({o_dc_ready, o_busy, o_frame_done, o_mb_load,
                                       o_tp_start, o_error}), 64'd0);
        check("rst_counts", 64'({o_draws_issued, o_draws_skipped}), 64'd0);
        check("rst_mb_fields", {o_mb_vertex_base, o_mb_vertex_count,
                                o_mb_index_base, o_mb_tri_count}, 64'd0);
        rstn = 1'b1;
        tick();
        check("rst_release_ready", 64'(o_dc_ready), 64'd1);
        while (exp_q.size() > n_load) void'(exp_q.pop_back());
        model_fill = 0;
        repeat (40) tick();
        check("rst_no_frame_done", 64'(n_done - bd), 64'd0);
        check("rst_loads", 64'(n_load - bl), 64'd2);
        run_frame(0, 0, 1'b0, 0, 0, "post_rst");

        // Random frames against the queue model
        for (int f = 0; f < 25; f++) begin
            int n, zm;
            bit fl;
            n  = $urandom_range(0, 18);
            zm = int'($urandom & $urandom);
            fl = 1'($urandom_range(0, 1));
            ready_rand = 1'($urandom_range(0, 1));
            tp_delay = $urandom_range(1, 15);
            acc_n = (n < MAXD) ? n : MAXD;
            skp = $countones(zm & ((1 << acc_n) - 1));
            run_frame(n, zm, fl, acc_n - skp, skp, $sformatf("rnd%0d", f));
        end
        ready_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_call_scheduler.md
DRAW_CALL_SCHEDULER -- requirements
Module: draw_call_scheduler

Interface
REQ-001 SHALL have parameter MAX_DRAWS, default 16, meaning draw-call queue depth (power of two).
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, meaning model-buffer base address width.
REQ-003 SHALL have parameter COUNT_WIDTH, default 14, meaning vertex/triangle count width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1048576, meaning max cycles for one draw in WAIT.
REQ-005 SHALL have ports clk in 1 (clock) and rstn in 1 (reset, synchronous, active-low).
REQ-006 SHALL have i_dc_valid in 1; o_dc_ready out 1; i_dc_vertex_base in ADDR_WIDTH; i_dc_vertex_count in COUNT_WIDTH; i_dc_index_base in ADDR_WIDTH; i_dc_tri_count in COUNT_WIDTH -- draw-call enqueue.
REQ-007 SHALL have i_frame_start in 1; o_frame_done out 1 (pulse); o_busy out 1; o_error out 1 (sticky timeout flag); i_error_clear in 1.
REQ-008 SHALL have o_mb_load out 1 (pulse); o_mb_vertex_base out ADDR_WIDTH; o_mb_vertex_count out COUNT_WIDTH; o_mb_index_base out ADDR_WIDTH; o_mb_tri_count out COUNT_WIDTH -- model-buffer configuration.
REQ-009 SHALL have o_tp_start out 1 (pulse); i_tp_ready in 1; i_tp_done in 1 -- transform pipeline control.
REQ-010 SHALL have o_draws_issued out COUNT_WIDTH and o_draws_skipped out COUNT_WIDTH, per-frame counters.

Function
REQ-011 SHALL store draw calls in a FIFO of MAX_DRAWS entries; enqueue occurs on a cycle where i_dc_valid & o_dc_ready.
REQ-012 SHALL drive o_dc_ready = 1 only in IDLE with FIFO not full; enqueue when full or not IDLE is ignored.
REQ-013 SHALL implement states IDLE, LOAD, START, WAIT, FRAME_DONE.
REQ-014 IDLE: i_frame_start -> clear both counters, o_busy=1 from next cycle; go to LOAD if FIFO non-empty, else FRAME_DONE.
REQ-015 i_frame_start and a valid enqueue in the same IDLE cycle SHALL both take effect; the new entry belongs to this frame.
REQ-016 LOAD: head entry with tri_count==0 or vertex_count==0 SHALL be popped, o_draws_skipped incremented, no o_mb_load; next LOAD if FIFO still non-empty, else FRAME_DONE.
REQ-017 LOAD, valid head: o_mb_load=1 for exactly one cycle with o_mb_* = head fields; go to START.
REQ-018 o_mb_* SHALL hold their last loaded values until the next o_mb_load.
REQ-019 START: when i_tp_ready=1, o_tp_start=1 for exactly one cycle, go to WAIT; else remain in START.
REQ-020 WAIT: on i_tp_done, pop head, increment o_draws_issued, go to LOAD if FIFO non-empty, else FRAME_DONE.
REQ-021 i_tp_done outside WAIT SHALL be ignored.
REQ-022 WAIT SHALL count cycles; reaching TIMEOUT_CYCLES without i_tp_done sets o_error=1, flushes the FIFO, goes to FRAME_DONE.
REQ-023 FRAME_DONE: o_frame_done=1 for exactly one cycle, then IDLE; o_busy=0 in IDLE.
REQ-024 o_error SHALL clear only on i_error_clear or reset; i_error_clear and a new timeout in the same cycle -> o_error=1.
REQ-025 Counters SHALL saturate at all-ones; FIFO pointers wrap modulo MAX_DRAWS.
REQ-026 Latency: i_frame_start to first o_mb_load = 2 cycles; o_mb_load to o_tp_start >= 1 cycle.

Reset
REQ-027 rstn=0 SHALL force IDLE, empty FIFO, all outputs 0 (o_dc_ready=1 from the first cycle after reset release), counters 0, o_error=0, including mid-frame.

Verification
REQ-028 Enqueue 3 draws (tri_count 4,0,7), frame_start, tp_ready=1, tp_done 10 cycles after each start -> 2 o_mb_load/o_tp_start pairs, draws_issued=2, draws_skipped=1, one o_frame_done.
REQ-029 frame_start with empty FIFO -> o_frame_done 2 cycles later, no o_mb_load, no o_tp_start.
REQ-030 Enqueue 17 entries with MAX_DRAWS=16 -> o_dc_ready=0 after 16th; 17th dropped; frame issues exactly 16.
REQ-031 TIMEOUT_CYCLES=100, never assert tp_done -> o_error=1 at cycle 100 of WAIT, FIFO empty, o_frame_done pulse; i_error_clear -> o_error=0.
REQ-032 Hold i_tp_ready=0 for 50 cycles in START -> o_tp_start stays 0, then a single pulse when ready rises.
REQ-033 Assert rstn=0 during WAIT of draw 2 of 4 -> next cycle IDLE, FIFO empty, all outputs 0, no o_frame_done.
